// File: rtl/rect_envelope_detector_pkg.sv
// Shared demod-chain definitions: rectifier mode encodings and a saturating absolute value.
package rect_pkg;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYP  = 2'b10;

  // |x| clamped to 2**(w-1)-1, so the most-negative w-bit value cannot wrap back negative.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (x >= 0)
      return $unsigned(x);
    else if (-x > lim)
      return $unsigned(lim);
    else
      return $unsigned(-x);
  endfunction

endpackage

// File: rtl/rect_sample_ring.sv
// Circular buffer of the last N rectified samples with write pointer and saturating fill count.
module rect_sample_ring
  import rect_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] oldest,
  output logic [AVG_LOG2:0] fill
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [DATA_W-1:0] mem [1 << PTR_W];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  ptr_next;

  // A clear restarts the window at slot 0 and hides every older entry.
  always_comb begin
    wr_idx   = clr ? '0 : wr_ptr;
    ptr_next = (wr_idx == PTR_W'(N - 1)) ? '0 : wr_idx + PTR_W'(1);
    oldest   = (!clr && fill == FILL_W'(N)) ? mem[wr_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= ptr_next;
      if (clr)
        fill <= FILL_W'(1);
      else if (fill != FILL_W'(N))
        fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/rect_envelope_detector.sv
// Rectifier (full/half/bypass) followed by a power-of-two boxcar average giving the AM envelope.
module rect_envelope_detector
  import rect_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  output logic              rect_valid,
  output logic [DATA_W-1:0] rect_out,
  output logic              env_valid,
  output logic [DATA_W-1:0] env_out,
  output logic              env_primed
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  function automatic logic [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] x,
                                                input logic [1:0] m);
    logic [31:0] a;
    a = sat_abs(32'(x), DATA_W);
    case (m)
      MODE_HALF: return x[DATA_W-1] ? '0 : x;
      MODE_BYP:  return x;
      default:   return a[DATA_W-1:0];
    endcase
  endfunction

  logic [1:0]        mode_prev;
  logic              clr_p1;
  logic [DATA_W-1:0] oldest;
  logic [FILL_W-1:0] fill;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;
  logic              primed_next;

  // ---- stage p1: rectify and flag a mode change for the averager ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rect_valid <= 1'b0;
      rect_out   <= '0;
      mode_prev  <= MODE_FULL;
      clr_p1     <= 1'b0;
    end else begin
      rect_valid <= in_valid;
      if (in_valid) begin
        rect_out  <= rectify(data_in, mode);
        mode_prev <= mode;
        clr_p1    <= (mode != mode_prev);
      end
    end
  end

  rect_sample_ring #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (rect_valid),
    .clr    (clr_p1),
    .wr_data(rect_out),
    .oldest (oldest),
    .fill   (fill)
  );

  // Running sum may wrap transiently before the subtraction; the final result always fits.
  always_comb begin
    acc_base    = clr_p1 ? '0 : acc;
    acc_next    = acc_base + ACC_W'(rect_out) - ACC_W'(oldest);
    primed_next = clr_p1 ? (N == 1) : (fill >= FILL_W'(N - 1));
  end

  // ---- stage p2: accumulate and register the envelope ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      env_valid  <= 1'b0;
      env_out    <= '0;
      env_primed <= 1'b0;
    end else begin
      env_valid <= rect_valid;
      if (rect_valid) begin
        acc        <= acc_next;
        env_out    <= acc_next[ACC_W-1:AVG_LOG2];
        env_primed <= primed_next;
      end
    end
  end

endmodule

// File: tb/tb_rect_envelope_detector.sv
// Directed bench for rect_envelope_detector (N=4 main instance, N=1 degenerate instance).
module tb_rect_envelope_detector;
  import rect_pkg::*;

  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [1:0]        mode = MODE_FULL;

  logic              rect_valid, env_valid, env_primed;
  logic [DATA_W-1:0] rect_out, env_out;
  logic              rect_valid0, env_valid0, env_primed0;
  logic [DATA_W-1:0] rect_out0, env_out0;

  int n_checks = 0;
  int n_fail   = 0;
  int cap_k    = 0;

  int seq_in  [8] = '{40, -80, 120, 1000, -1000, 5, 300, -2048};
  int seq_env [8] = '{10, 30, 60, 310, 550, 531, 576, 838};

  rect_envelope_detector #(.DATA_W(DATA_W), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .mode(mode),
    .rect_valid(rect_valid), .rect_out(rect_out), .env_valid(env_valid),
    .env_out(env_out), .env_primed(env_primed)
  );

  rect_envelope_detector #(.DATA_W(DATA_W), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .mode(mode),
    .rect_valid(rect_valid0), .rect_out(rect_out0), .env_valid(env_valid0),
    .env_out(env_out0), .env_primed(env_primed0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic drive(input logic v, input int x, input logic [1:0] m);
    in_valid = v;
    data_in  = x[DATA_W-1:0];
    mode     = m;
    @(negedge clk);
  endtask

  task automatic capture(input string tag);
    if (env_valid) begin
      if (cap_k < 8) check_eq(tag, {20'd0, env_out}, seq_env[cap_k]);
      cap_k++;
    end
  endtask

  task automatic run_seq(input int gap, input string tag);
    cap_k = 0;
    rst = 1'b1;
    drive(1'b0, 0, MODE_FULL);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq_in[i], MODE_FULL);
      capture(tag);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 0, MODE_FULL);
        capture(tag);
      end
    end
    for (int t = 0; t < 2; t++) begin
      drive(1'b0, 0, MODE_FULL);
      capture(tag);
    end
    check_eq({tag, "_count"}, cap_k, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 0, MODE_FULL);
    drive(1'b0, 0, MODE_FULL);
    check_eq("rst_rect_valid", rect_valid, 0);
    check_eq("rst_rect_out",   rect_out,   0);
    check_eq("rst_env_valid",  env_valid,  0);
    check_eq("rst_env_out",    env_out,    0);
    check_eq("rst_env_primed", env_primed, 0);
    rst = 1'b0;

    // full-wave incl. saturation of the most-negative code
    drive(1'b1, 100, MODE_FULL);
    check_eq("fw_rect_valid", rect_valid, 1);
    check_eq("fw_100", rect_out, 100);
    drive(1'b1, -100, MODE_FULL);
    check_eq("fw_m100", rect_out, 100);
    drive(1'b1, -2048, MODE_FULL);
    check_eq("fw_m2048", rect_out, 2047);
    drive(1'b1, 2047, MODE_FULL);
    check_eq("fw_2047", rect_out, 2047);
    drive(1'b0, 0, MODE_FULL);
    check_eq("fw_rect_valid_low", rect_valid, 0);
    check_eq("fw_rect_hold", rect_out, 2047);
    check_eq("fw_env_valid", env_valid, 1);
    check_eq("fw_env", env_out, 1073);
    check_eq("fw_primed", env_primed, 1);
    check_eq("n1_env", env_out0, 2047);
    check_eq("n1_primed", env_primed0, 1);
    drive(1'b0, 0, MODE_FULL);
    check_eq("gap_env_valid_low", env_valid, 0);
    check_eq("gap_env_hold", env_out, 1073);

    // half-wave, reserved mode, bypass
    drive(1'b1, -5, MODE_HALF);
    check_eq("hw_m5", rect_out, 0);
    drive(1'b1, 7, MODE_HALF);
    check_eq("hw_7", rect_out, 7);
    check_eq("hw_env_restart", env_out, 0);
    check_eq("hw_primed_drop", env_primed, 0);
    drive(1'b1, -5, 2'b11);
    check_eq("rsv_m5", rect_out, 5);
    check_eq("hw_env_7", env_out, 1);
    drive(1'b1, -1, MODE_BYP);
    check_eq("byp_m1", rect_out, 4095);
    check_eq("rsv_env", env_out, 1);
    check_eq("rsv_primed", env_primed, 0);

    // constant 400, window of 4
    rst = 1'b1;
    drive(1'b0, 0, MODE_FULL);
    rst = 1'b0;
    drive(1'b1, 400, MODE_FULL);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, 400, MODE_FULL);
      else       drive(1'b0, 0, MODE_FULL);
      check_eq($sformatf("const_env_%0d", i), env_out, (i < 3) ? 100 * (i + 1) : 400);
      check_eq($sformatf("const_primed_%0d", i), env_primed, (i >= 3) ? 1 : 0);
    end

    // mode switch mid-stream restarts the window without losing samples
    drive(1'b1, 200, MODE_HALF);
    check_eq("sw_rect", rect_out, 200);
    drive(1'b1, -300, MODE_HALF);
    check_eq("sw_env_1", env_out, 50);
    check_eq("sw_primed_1", env_primed, 0);
    drive(1'b1, 200, MODE_HALF);
    check_eq("sw_env_2", env_out, 50);
    drive(1'b1, 200, MODE_HALF);
    check_eq("sw_env_3", env_out, 100);
    check_eq("sw_primed_3", env_primed, 0);
    drive(1'b0, 0, MODE_HALF);
    check_eq("sw_env_4", env_out, 150);
    check_eq("sw_primed_4", env_primed, 1);

    // same data continuous and with 1-in-3 valid pattern
    run_seq(0, "cont");
    run_seq(2, "gap3");

    // reset with samples in flight
    drive(1'b1, 500, MODE_FULL);
    drive(1'b1, 600, MODE_FULL);
    rst = 1'b1;
    drive(1'b1, 700, MODE_FULL);
    check_eq("midrst_rect_valid", rect_valid, 0);
    check_eq("midrst_rect_out",   rect_out,   0);
    check_eq("midrst_env_valid",  env_valid,  0);
    check_eq("midrst_env_out",    env_out,    0);
    check_eq("midrst_env_primed", env_primed, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, MODE_FULL);
      check_eq($sformatf("post_rst_valids_%0d", i), {rect_valid, env_valid}, 0);
      check_eq($sformatf("post_rst_env_%0d", i), env_out, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
